// File: rtl/fp_exp2_pkg.sv
// Shared types and constants for the 2^x unit, plus the elaboration-time C_k table builder.
// Latency: none (definitions only).
// Backpressure: not applicable.
package fp_exp2_pkg;

    localparam int FRAC_W = 24;
    localparam int ACC_W  = 32;
    localparam int ITER_N = 24;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]      PINF    = 32'h7F80_0000;
    localparam logic [31:0]      ONE     = 32'h3F80_0000;
    localparam logic [ACC_W-1:0] ACC_ONE = 32'h4000_0000;

    typedef enum logic [2:0] {ST_IDLE, ST_CONV, ST_ITER, ST_PACK, ST_DONE} state_t;

    typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_PINF, SP_NINF, SP_OVF, SP_UFL} special_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } status_t;

    typedef logic [31:0][ACC_W-1:0] c_tab_t;

    // Round-to-nearest integer square root, used only to build constant tables.
    function automatic logic [31:0] isqrt_rnd(input logic [63:0] v);
        logic [31:0] r;
        logic [31:0] t;
        logic [63:0] rem;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            t = r | (32'd1 << i);
            if (({32'd0, t} * {32'd0, t}) <= v) r = t;
        end
        rem = v - ({32'd0, r} * {32'd0, r});
        if (rem > {32'd0, r}) r = r + 32'd1;
        return r;
    endfunction

    // C_k = 2^(2^-k) in Q2.30 is the square root of C_(k-1), starting from 2.0.
    function automatic c_tab_t build_c_tab();
        c_tab_t           t;
        logic [ACC_W-1:0] c;
        c = 32'h8000_0000;
        for (int k = 0; k < 32; k++) begin
            if (k >= 1 && k <= ITER_N) begin
                c = isqrt_rnd({2'b00, c, 30'd0});
                t[5'(k)] = c;
            end else begin
                t[5'(k)] = ACC_ONE;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/fp_exp2_rom.sv
// Constant table of C_k = 2^(2^-k) in Q2.30; index 0 and above 24 give 1.0.
// Latency: combinational.
// Backpressure: none.
module fp_exp2_rom
    import fp_exp2_pkg::*;
(
    input  logic [4:0]       k,
    output logic [ACC_W-1:0] c_k
);

    localparam c_tab_t C_TAB = build_c_tab();

    assign c_k = C_TAB[k];

endmodule

// File: rtl/fp_exp2.sv
// binary32 2^x from XOR-shared operand via shift-and-multiply over the fraction bits; FP_EXP2_ROUND_EN selects RNE over truncation.
// Latency: fixed 26 cycles from accept to out_valid for every operand.
// Backpressure: one operation in flight; in_ready only when idle, result held in DONE until out_ready.
module fp_exp2
    import fp_exp2_pkg::*;
#(
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   g_input,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   e_input,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   o,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2:0]                     status
);

    localparam int W = SIG_WIDTH + EXP_WIDTH + 1;

    state_t            state_q, state_d;
    logic [W-1:0]      g_q, e_q, num, o_q;
    logic [7:0]        int_q;
    logic [FRAC_W-1:0] frac_q;
    special_t          special_q, special;
    logic [4:0]        cnt_q;
    logic [ACC_W-1:0]  acc_q, acc_nxt, c_k;
    logic [63:0]       prod;
    status_t           status_q, res_st;
    logic [31:0]       res;

    logic              sgn;
    logic [7:0]        bexp;
    logic [23:0]       mant24;
    logic [31:0]       mag, fix;
    logic              rnd_up;
    logic [23:0]       mant_sum;
    logic [9:0]        e_sum;
    logic              e_ufl, e_ovf;
    logic              dp_unused;

    // CONV: shares are combined only after registration
    assign num    = g_q ^ e_q;
    assign sgn    = num[31];
    assign bexp   = num[30:23];
    assign mant24 = {1'b1, num[22:0]};

    // Magnitude in Q8.24; anything below 2^-24 truncates to zero
    always_comb begin
        mag = '0;
        if (bexp >= 8'd126)
            mag = {8'd0, mant24} << (bexp - 8'd126);
        else if (bexp >= 8'd103)
            mag = {8'd0, mant24} >> (8'd126 - bexp);
    end

    assign fix = sgn ? (~mag + 32'd1) : mag;

    always_comb begin
        special = SP_NONE;
        if (bexp == 8'hFF)
            special = (num[22:0] != 23'd0) ? SP_NAN : (sgn ? SP_NINF : SP_PINF);
        else if (bexp >= 8'd134)
            special = sgn ? SP_UFL : SP_OVF;
        else if (sgn && mag > 32'h7E00_0000)
            special = SP_UFL;
    end

    // ITER: single multiplier shared across all iterations
    fp_exp2_rom u_rom (
        .k   (cnt_q),
        .c_k (c_k)
    );

    assign prod    = {32'd0, acc_q} * {32'd0, c_k};
    assign acc_nxt = frac_q[FRAC_W-1] ? prod[61:30] : acc_q;

`ifdef FP_EXP2_ROUND_EN
    assign rnd_up = acc_q[6] & (acc_q[7] | (|acc_q[5:0]));
`else
    assign rnd_up = 1'b0;
`endif

    // PACK: mantissa carry bumps the exponent
    assign mant_sum = {1'b0, acc_q[29:7]} + {23'd0, rnd_up};
    assign e_sum    = {{2{int_q[7]}}, int_q} + {2'd0, ONE[30:23]} + {9'd0, mant_sum[23]};
    assign e_ufl    = e_sum[9] | (e_sum == 10'd0);
    assign e_ovf    = ~e_sum[9] & (e_sum > 10'd254);

    always_comb begin
        res    = '0;
        res_st = '0;
        case (special_q)
            SP_NAN:  begin res = QNAN; res_st.invalid   = 1'b1; end
            SP_PINF: res = PINF;
            SP_NINF: res = '0;
            SP_OVF:  begin res = PINF; res_st.overflow  = 1'b1; end
            SP_UFL:  begin res = '0;   res_st.underflow = 1'b1; end
            default: begin
                if (e_ovf) begin
                    res             = PINF;
                    res_st.overflow = 1'b1;
                end else if (e_ufl) begin
                    res              = '0;
                    res_st.underflow = 1'b1;
                end else begin
                    res = {1'b0, e_sum[7:0], mant_sum[22:0]};
                end
            end
        endcase
    end

    assign dp_unused = ^{acc_q[31:30], acc_q[6:0], prod[63:62], prod[29:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_CONV;
            end
            ST_CONV: state_d = ST_ITER;
            ST_ITER: if (cnt_q == 5'(ITER_N)) state_d = ST_PACK;
            ST_PACK: state_d = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q       <= '0;
            e_q       <= '0;
            int_q     <= '0;
            frac_q    <= '0;
            special_q <= SP_NONE;
            cnt_q     <= '0;
            acc_q     <= '0;
            o_q       <= '0;
            status_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    g_q <= g_input;
                    e_q <= e_input;
                end
                ST_CONV: begin
                    int_q     <= fix[31:24];
                    frac_q    <= fix[23:0];
                    special_q <= special;
                    acc_q     <= ACC_ONE;
                    cnt_q     <= 5'd1;
                end
                ST_ITER: begin
                    acc_q  <= acc_nxt;
                    frac_q <= frac_q << 1;
                    cnt_q  <= cnt_q + 5'd1;
                end
                ST_PACK: begin
                    o_q      <= res;
                    status_q <= res_st;
                end
                default: ;
            endcase
        end
    end

    assign o      = o_q;
    assign status = status_q;

endmodule

// File: tb/tb_fp_exp2.sv
// Directed bench for fp_exp2: scoreboard queue of expected results, immediate-assertion checks.
// Latency, backpressure hold and mid-operation reset are exercised alongside the value cases.
// Stimulus and sampling happen on the falling clock edge.
module tb_fp_exp2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] g_input, e_input, o;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  status;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] o;
        logic [2:0]  st;
        bit          tol;
    } want_t;

    want_t sb[$];

    fp_exp2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .g_input   (g_input),
        .e_input   (e_input),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o         (o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .status    (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] want);
        logic [31:0] diff;
        diff = (obs > want) ? obs - want : want - obs;
        checks++;
        assert (diff <= 32'd1) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h (+/-1)", tag, obs, want);
        end
    endtask

    // Caller is positioned at a falling edge; returns at the first falling edge with out_valid high.
    task automatic send(input string tag, input logic [31:0] g, input logic [31:0] e,
                        input logic [31:0] want_o, input logic [2:0] want_st, input bit tol);
        want_t w;
        want_t got;
        int    start;
        int    n;
        w.o = want_o; w.st = want_st; w.tol = tol;
        sb.push_back(w);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        g_input  = g;
        e_input  = e;
        in_valid = 1'b1;
        start    = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        g_input  = $urandom;
        e_input  = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(cyc - start), 32'd26);
        got = sb.pop_front();
        if (got.tol) chk_near({tag, " o"}, o, got.o);
        else         chk({tag, " o"}, o, got.o);
        chk({tag, " status"}, {29'd0, status}, {29'd0, got.st});
    endtask

    task automatic send_num(input string tag, input logic [31:0] num,
                            input logic [31:0] want_o, input logic [2:0] want_st, input bit tol);
        logic [31:0] g;
        g = $urandom;
        send(tag, g, g ^ num, want_o, want_st, tol);
    endtask

    initial begin
        int seen;
        in_valid  = 1'b0;
        g_input   = '0;
        e_input   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst o", o, 32'h0);
        chk("rst status", {29'd0, status}, 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        send("one", 32'h0, 32'h3F80_0000, 32'h4000_0000, 3'b000, 1'b0);
        send("three", 32'h1234_5678, 32'h1234_5678 ^ 32'h4040_0000, 32'h4100_0000, 3'b000, 1'b0);
        send_num("neg_one", 32'hBF80_0000, 32'h3F00_0000, 3'b000, 1'b0);
        send_num("half", 32'h3F00_0000, 32'h3FB5_04F3, 3'b000, 1'b1);
        send_num("neg_half", 32'hBF00_0000, 32'h3F35_04F3, 3'b000, 1'b1);
        send_num("two_half", 32'h4020_0000, 32'h40B5_04F3, 3'b000, 1'b1);
        send_num("m126", 32'hC2FC_0000, 32'h0080_0000, 3'b000, 1'b0);
        send_num("m127", 32'hC2FE_0000, 32'h0000_0000, 3'b001, 1'b0);
        send_num("p127", 32'h42FE_0000, 32'h7F00_0000, 3'b000, 1'b0);
        send_num("p128", 32'h4300_0000, 32'h7F80_0000, 3'b010, 1'b0);
        send_num("m150", 32'hC316_0000, 32'h0000_0000, 3'b001, 1'b0);
        send_num("nan", 32'h7FC0_0000, 32'h7FC0_0000, 3'b100, 1'b0);
        send_num("pinf", 32'h7F80_0000, 32'h7F80_0000, 3'b000, 1'b0);
        send_num("ninf", 32'hFF80_0000, 32'h0000_0000, 3'b000, 1'b0);
        send_num("pzero", 32'h0000_0000, 32'h3F80_0000, 3'b000, 1'b0);
        send_num("nzero", 32'h8000_0000, 32'h3F80_0000, 3'b000, 1'b0);
        send_num("tiny", 32'h3080_0000, 32'h3F80_0000, 3'b000, 1'b0);

        // Result must stay put while the consumer stalls
        @(negedge clk);
        out_ready = 1'b0;
        send_num("stall", 32'h4000_0000, 32'h4080_0000, 3'b000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall o", o, 32'h4080_0000);
            chk("stall status", {29'd0, status}, 32'd0);
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release out_valid", 32'(out_valid), 32'd0);
        chk("release in_ready", 32'(in_ready), 32'd1);
        send_num("b2b", 32'h4040_0000, 32'h4100_0000, 3'b000, 1'b0);

        // Reset in the middle of ITER drops the operation
        @(negedge clk);
        @(negedge clk);
        g_input  = 32'h0;
        e_input  = 32'h4040_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst out_valid", 32'(seen), 32'd0);
        chk("midrst o", o, 32'h0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        send("after_rst", 32'h0, 32'h3F80_0000, 32'h4000_0000, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
